// File: rtl/seq_detect_prog_if.sv
// Serial-bit, configuration and status bundle for the programmable sequence detector.
// The DUT takes the slave side; the stimulus or upstream framer takes the master side.
interface seq_detect_prog_if #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
);
  logic               inp_bit;
  logic               inp_valid;
  logic               cfg_load;
  logic [MAX_LEN-1:0] cfg_pattern;
  logic [LEN_W-1:0]   cfg_len;
  logic               cfg_overlap;
  logic               count_clr;
  logic               seq_seen;
  logic [CNT_W-1:0]   match_count;
  logic               armed;

  modport master (
    output inp_bit, inp_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, count_clr,
    input  seq_seen, match_count, armed
  );

  modport slave (
    input  inp_bit, inp_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, count_clr,
    output seq_seen, match_count, armed
  );
endinterface

// File: rtl/seq_detect_prog.sv
// Runtime-programmable serial sequence detector: full-window compare of the last len bits.
// seq_seen is registered one cycle after the completing bit; no backpressure, one bit per cycle.
module seq_detect_prog #(
  parameter int MAX_LEN = 8,
  parameter int LEN_W   = $clog2(MAX_LEN + 1),
  parameter int CNT_W   = 8
) (
  input logic              clk,
  input logic              reset,
  seq_detect_prog_if.slave bus
);

  typedef enum logic {UNCFG, RUN} state_t;

  state_t             state;
  logic [MAX_LEN-2:0] hist;
  logic [LEN_W-1:0]   fill;
  logic [MAX_LEN-1:0] pattern;
  logic [LEN_W-1:0]   len;
  logic               overlap;
  logic               seq_seen_q;
  logic [CNT_W-1:0]   cnt;
  logic               armed_q;

  logic [MAX_LEN-1:0] nhist;
  logic [MAX_LEN-1:0] mask;
  logic [LEN_W-1:0]   nfill;
  logic [LEN_W-1:0]   len_clamped;
  logic               sample;
  logic               match;

  always_comb begin
    nhist       = {hist, bus.inp_bit};
    nfill       = (fill >= LEN_W'(MAX_LEN)) ? fill : fill + LEN_W'(1);
    len_clamped = (bus.cfg_len > LEN_W'(MAX_LEN)) ? LEN_W'(MAX_LEN) : bus.cfg_len;
    mask        = '0;
    for (int i = 0; i < MAX_LEN; i++) begin
      mask[i] = (LEN_W'(i) < len);
    end
    // A load in the same cycle wins over the data bit.
    sample = (state == RUN) && bus.inp_valid && !bus.cfg_load;
    match  = sample && (nfill >= len) && (((nhist ^ pattern) & mask) == '0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= UNCFG;
      hist       <= '0;
      fill       <= '0;
      pattern    <= '0;
      len        <= '0;
      overlap    <= 1'b0;
      seq_seen_q <= 1'b0;
      cnt        <= '0;
      armed_q    <= 1'b0;
    end else begin
      seq_seen_q <= 1'b0;
      if (bus.cfg_load) begin
        pattern <= bus.cfg_pattern;
        overlap <= bus.cfg_overlap;
        len     <= len_clamped;
        hist    <= '0;
        fill    <= '0;
        state   <= (len_clamped != '0) ? RUN : UNCFG;
        armed_q <= (len_clamped != '0);
      end else if (sample) begin
        hist       <= nhist[MAX_LEN-2:0];
        seq_seen_q <= match;
        // Non-overlapping mode restarts the window so matched bits are never reused.
        fill       <= (match && !overlap) ? '0 : nfill;
      end

      if (bus.count_clr) begin
        cnt <= '0;
      end else if (match && (cnt != '1)) begin
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  assign bus.seq_seen    = seq_seen_q;
  assign bus.match_count = cnt;
  assign bus.armed       = armed_q;

endmodule

// File: tb/tb_seq_detect_prog.sv
// Directed bench for seq_detect_prog: an 8-bit counter instance plus a 2-bit counter instance fed the same stimulus.
module tb_seq_detect_prog;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  always #5 clk = ~clk;

  seq_detect_prog_if #(.MAX_LEN(8), .CNT_W(8)) b1 ();
  seq_detect_prog_if #(.MAX_LEN(8), .CNT_W(2)) b2 ();

  assign b2.inp_bit     = b1.inp_bit;
  assign b2.inp_valid   = b1.inp_valid;
  assign b2.cfg_load    = b1.cfg_load;
  assign b2.cfg_pattern = b1.cfg_pattern;
  assign b2.cfg_len     = b1.cfg_len;
  assign b2.cfg_overlap = b1.cfg_overlap;
  assign b2.count_clr   = b1.count_clr;

  seq_detect_prog #(.MAX_LEN(8), .CNT_W(8)) u_dut  (.clk(clk), .reset(reset), .bus(b1.slave));
  seq_detect_prog #(.MAX_LEN(8), .CNT_W(2)) u_dut2 (.clk(clk), .reset(reset), .bus(b2.slave));

  task automatic chk(input logic [31:0] obs, input logic [31:0] exp, input string tag);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    reset = 1'b0;
  endtask

  task automatic load(input logic [7:0] pat, input logic [3:0] len, input logic ov);
    b1.cfg_load    = 1'b1;
    b1.cfg_pattern = pat;
    b1.cfg_len     = len;
    b1.cfg_overlap = ov;
    tick();
    b1.cfg_load = 1'b0;
  endtask

  task automatic clr();
    b1.count_clr = 1'b1;
    tick();
    b1.count_clr = 1'b0;
  endtask

  task automatic send(input logic b, input logic exp_seen, input string tag);
    b1.inp_bit   = b;
    b1.inp_valid = 1'b1;
    tick();
    b1.inp_valid = 1'b0;
    chk(b1.seq_seen, exp_seen, tag);
  endtask

  task automatic idle(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      tick();
      chk(b1.seq_seen, 1'b0, $sformatf("%s_gap%0d", tag, k));
    end
  endtask

  // Bits and expected pulses are listed MSB-first: index n-1 is sent first.
  task automatic run_stream(input logic [15:0] bits, input logic [15:0] exp, input int n, input string tag);
    for (int i = n - 1; i >= 0; i--) begin
      send(bits[i], exp[i], $sformatf("%s_b%0d", tag, n - i));
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    b1.inp_bit     = 1'b0;
    b1.inp_valid   = 1'b0;
    b1.cfg_load    = 1'b0;
    b1.cfg_pattern = '0;
    b1.cfg_len     = '0;
    b1.cfg_overlap = 1'b0;
    b1.count_clr   = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;

    chk(b1.seq_seen, 1'b0, "rst_seen");
    chk(b1.match_count, 8'd0, "rst_count");
    chk(b1.armed, 1'b0, "rst_armed");
    chk(b2.match_count, 2'd0, "rst_count2");

    // Overlapping 1011 on 1,0,1,1,0,1,1
    load(8'b0000_1011, 4'd4, 1'b1);
    chk(b1.armed, 1'b1, "ov_armed");
    run_stream(16'b1011011, 16'b0001001, 7, "ov");
    chk(b1.match_count, 8'd2, "ov_count");
    idle(1, "ov_after");

    // Non-overlapping, same stream
    clr();
    chk(b1.match_count, 8'd0, "clr_count");
    load(8'b0000_1011, 4'd4, 1'b0);
    run_stream(16'b1011011, 16'b0001000, 7, "nov");
    chk(b1.match_count, 8'd1, "nov_count");

    // Prefix retention: 1,1,0,1,1 then the same with idle gaps
    clr();
    load(8'b0000_1011, 4'd4, 1'b1);
    run_stream(16'b11011, 16'b00001, 5, "pre");
    load(8'b0000_1011, 4'd4, 1'b1);
    send(1'b1, 1'b0, "gap_b1");
    idle(1, "g1");
    send(1'b1, 1'b0, "gap_b2");
    idle(2, "g2");
    send(1'b0, 1'b0, "gap_b3");
    idle(3, "g3");
    send(1'b1, 1'b0, "gap_b4");
    idle(1, "g4");
    send(1'b1, 1'b1, "gap_b5");
    idle(2, "g5");
    chk(b1.match_count, 8'd2, "gap_count");

    // Zero length leaves the detector unarmed
    load(8'h0F, 4'd0, 1'b1);
    chk(b1.armed, 1'b0, "len0_armed");
    run_stream(16'b1111, 16'b0000, 4, "len0");
    chk(b1.match_count, 8'd2, "len0_count");

    // Oversized length clamps to the full 8-bit window
    load(8'hA5, 4'd11, 1'b1);
    chk(b1.armed, 1'b1, "clamp_armed");
    run_stream(16'h00A5, 16'h0001, 8, "clamp");
    chk(b1.match_count, 8'd3, "clamp_count");

    // len=1 with a 2-bit saturating counter
    do_reset();
    chk(b2.match_count, 2'd0, "sat_rst");
    load(8'h01, 4'd1, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      send(1'b1, 1'b1, $sformatf("sat_seen%0d", i));
      chk(b2.match_count, (i > 3) ? 32'd3 : 32'(i), $sformatf("sat_cnt2_%0d", i));
      chk(b1.match_count, 32'(i), $sformatf("sat_cnt8_%0d", i));
    end
    b1.count_clr = 1'b1;
    send(1'b1, 1'b1, "clr_match_seen");
    b1.count_clr = 1'b0;
    chk(b2.match_count, 2'd0, "clr_match_cnt2");
    chk(b1.match_count, 8'd0, "clr_match_cnt8");
    load(8'h01, 4'd1, 1'b0);
    run_stream(16'b1101, 16'b1101, 4, "len1_nov");
    chk(b1.match_count, 8'd3, "len1_nov_count");

    // Reset mid-stream loses the partial history and disarms
    load(8'b0000_1011, 4'd4, 1'b1);
    run_stream(16'b101, 16'b000, 3, "mid");
    do_reset();
    chk(b1.seq_seen, 1'b0, "mid_rst_seen");
    chk(b1.match_count, 8'd0, "mid_rst_count");
    chk(b1.armed, 1'b0, "mid_rst_armed");
    send(1'b1, 1'b0, "mid_uncfg_bit");
    chk(b1.armed, 1'b0, "mid_uncfg_armed");
    load(8'b0000_1011, 4'd4, 1'b1);
    run_stream(16'b11, 16'b00, 2, "mid_short");
    run_stream(16'b1011, 16'b0001, 4, "mid_full");
    chk(b1.match_count, 8'd1, "mid_count");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/seq_detect_prog.md
Name: seq_detect_prog

Overview:
- Runtime-programmable serial bit-sequence detector.
- Pattern of 1..MAX_LEN bits is loaded through a config port; overlapping or non-overlapping detection is selectable.
- Accepts one qualified bit per cycle, pulses seq_seen on each match and keeps a saturating match count.
- Sits on serial framing / sync-word paths, replacing the fixed-pattern detectors.

Parameters:
- MAX_LEN, 8, maximum pattern length in bits (>=2).
- LEN_W, $clog2(MAX_LEN+1), width of the length field.
- CNT_W, 8, width of the match counter.

Ports:
- clk  input  1  clock, all logic on posedge.
- reset  input  1  synchronous active-high reset.
- inp_bit  input  1  serial data bit.
- inp_valid  input  1  inp_bit is sampled this cycle.
- cfg_load  input  1  load the cfg_* fields this cycle.
- cfg_pattern  input  MAX_LEN  pattern bits. cfg_pattern[len-1] is the first bit received; cfg_pattern[0] is the last.
- cfg_len  input  LEN_W  pattern length.
- cfg_overlap  input  1  1 = overlapping detection, 0 = non-overlapping.
- count_clr  input  1  clear match_count.
- seq_seen  output  1  one-cycle match pulse.
- match_count  output  CNT_W  saturating number of matches.
- armed  output  1  high in state RUN.

Behaviour:
- Reset (sync, highest priority): state=UNCFG; hist=0, fill=0, pattern=0, len=0, overlap=0; seq_seen=0, match_count=0, armed=0.
- States:
  - UNCFG: bits are ignored.
  - RUN: detecting.
- cfg_load (any state, priority over inp_valid, which is ignored that cycle):
  - Latch pattern and overlap.
  - len = min(cfg_len, MAX_LEN).
  - Clear hist, fill and seq_seen; match_count is unchanged.
  - Next state: RUN if the clamped len >= 1, else UNCFG.
- RUN with inp_valid=1:
  - nhist = {hist[MAX_LEN-2:0], inp_bit}; the newest bit is at the LSB.
  - nfill = min(fill+1, MAX_LEN).
  - match = (nfill >= len) AND (nhist[len-1:0] == pattern[len-1:0]).
  - hist <= nhist; seq_seen <= match.
  - fill <= (match AND overlap==0) ? 0 : nfill.
- Latency: seq_seen is high exactly in the cycle after the clock edge that samples the completing bit. It is a single-cycle pulse, and stays high only if the next sampled bit also completes a match.
- inp_valid=0 or state UNCFG: hist, fill and state hold; seq_seen <= 0.
- Non-overlap: bits of a matched window are never reused; the next match needs len fresh bits.
- Detection is a full window compare, not a partial-match FSM, so no prefix is ever lost. Example: 1,1,0,1,1 matches 1011.
- match_count:
  - +1 on each match; saturates at all-ones and does not wrap.
  - count_clr zeroes it. If count_clr coincides with a match, the result is 0.
  - Reset zeroes it.
- len=1: every sampled bit equal to pattern[0] matches, in both overlap modes.
- len=MAX_LEN: the entire hist is compared.
- Reset mid-stream: the partial history is lost and the block must be reconfigured before detecting again.
- armed = (state==RUN), registered.

Test Plan:
- Reset, then load pattern=4'b1011, len=4, overlap=1; stream 1,0,1,1,0,1,1 on consecutive valid cycles -> seq_seen pulses after bit 4 and bit 7; match_count=2; armed=1.
- Same stream with overlap=0 -> a single pulse after bit 4; match_count=1.
- Pattern 1011, stream 1,1,0,1,1 -> a pulse after bit 5 (the prefix is retained). Repeat with inp_valid=0 gaps of 1–3 cycles between bits -> same pulses, shifted by the gaps, with seq_seen=0 during every gap.
- cfg_len=0 -> armed=0 and no pulses on any stream. cfg_len=MAX_LEN+3 -> behaves as len=MAX_LEN; with the 8-bit pattern 8'hA5 only, the stream A5 yields one pulse.
- CNT_W=2, pattern=1 (len=1, overlap=1), stream of five 1s -> match_count goes 1,2,3,3,3. count_clr asserted with a match -> match_count=0.
- Assert reset after bits 1,0,1 of 1011 -> outputs are zero and armed=0. After reload, the stream 1,1 produces no pulse and the full stream 1,0,1,1 produces exactly one pulse.
